// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state, word-length and stop-bit encodings
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        STOP2
    } uart_state_t;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    localparam logic STB_1 = 1'b0;
    localparam logic STB_2 = 1'b1;

    // Index of the final data bit for a given word-length code (4..7).
    function automatic logic [2:0] last_bit_idx(input logic [1:0] wls);
        return 3'd4 + {1'b0, wls};
    endfunction

endpackage

// File: rtl/slib_counter.sv
// rtl/slib_counter.sv - free-running up counter with synchronous clear and enable
module slib_counter #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CLEAR,
    input  logic             ENABLE,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_count <= '0;
        end else if (CLEAR) begin
            r_count <= '0;
        end else if (ENABLE) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign Q = r_count;

endmodule

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART serialiser with parity and 1/1.5/2 stop bits; UART_TX_BREAK_EN adds break control
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       TXCLK,
    input  logic       TXSTART,
    input  logic       CLEAR,
    input  logic [1:0] WLS,
    input  logic       STB,
    input  logic       PEN,
    input  logic       EPS,
    input  logic       SP,
    input  logic       BC,
    input  logic [7:0] DIN,
    output logic       SOUT,
    output logic       TXFINISHED
);

    localparam logic [3:0] C_FULL = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] C_HALF = 4'(OVERSAMPLE / 2 - 1);

    uart_state_t r_state;
    uart_state_t w_state_next;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_next;
    logic [2:0]  r_bitcnt;
    logic [2:0]  w_bitcnt_next;
    logic        r_par;
    logic        w_par_next;
    logic [1:0]  r_wls;
    logic        r_stb;
    logic        r_pen;
    logic        r_eps;
    logic        r_sp;
    logic        r_sout;
    logic        r_finished;
    logic        w_capture;
    logic        w_done;
    logic        w_sout_next;
    logic [3:0]  w_baud_cnt;
    logic [3:0]  w_limit;
    logic        w_bit_end;
    logic        w_baud_clear;

    // Counter restarts at every bit boundary so each state sees a fresh count.
    assign w_baud_clear = CLEAR || (r_state == IDLE) || w_bit_end;

    slib_counter #(
        .WIDTH(4)
    ) u_baud_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CLEAR (w_baud_clear),
        .ENABLE(TXCLK),
        .Q     (w_baud_cnt)
    );

    assign w_limit   = (r_state == STOP2 && r_wls == WLS_5) ? C_HALF : C_FULL;
    assign w_bit_end = TXCLK && (w_baud_cnt == w_limit);

    always_comb begin
        w_state_next  = r_state;
        w_shift_next  = r_shift;
        w_bitcnt_next = r_bitcnt;
        w_par_next    = r_par;
        w_capture     = 1'b0;
        w_done        = 1'b0;

        case (r_state)
            IDLE: begin
                if (TXSTART) begin
                    w_state_next = START;
                    w_capture    = 1'b1;
                    w_shift_next = DIN;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_next  = DATA;
                    w_bitcnt_next = 3'd0;
                    w_par_next    = 1'b0;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_par_next   = r_par ^ r_shift[0];
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bitcnt == last_bit_idx(r_wls)) begin
                        w_state_next = r_pen ? PAR : STOP;
                    end else begin
                        w_bitcnt_next = r_bitcnt + 3'd1;
                    end
                end
            end
            PAR: begin
                if (w_bit_end) begin
                    w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    if (r_stb == STB_2) begin
                        w_state_next = STOP2;
                    end else begin
                        w_state_next = IDLE;
                        w_done       = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (w_bit_end) begin
                    w_state_next = IDLE;
                    w_done       = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (CLEAR) begin
            w_state_next = IDLE;
            w_capture    = 1'b0;
            w_done       = 1'b0;
            w_shift_next = r_shift;
        end
    end

    // Line level is derived from the upcoming state so SOUT stays registered.
    always_comb begin
        w_sout_next = 1'b1;
        case (w_state_next)
            START:   w_sout_next = 1'b0;
            DATA:    w_sout_next = w_shift_next[0];
            PAR:     w_sout_next = r_sp ? ~r_eps : (w_par_next ^ ~r_eps);
            default: w_sout_next = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= IDLE;
            r_shift    <= 8'h00;
            r_bitcnt   <= 3'd0;
            r_par      <= 1'b0;
            r_wls      <= WLS_8;
            r_stb      <= STB_1;
            r_pen      <= 1'b0;
            r_eps      <= 1'b0;
            r_sp       <= 1'b0;
            r_sout     <= 1'b1;
            r_finished <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_bitcnt   <= w_bitcnt_next;
            r_par      <= w_par_next;
            r_finished <= w_done;
            if (w_capture) begin
                r_wls <= WLS;
                r_stb <= STB;
                r_pen <= PEN;
                r_eps <= EPS;
                r_sp  <= SP;
            end
`ifdef UART_TX_BREAK_EN
            r_sout <= BC ? 1'b0 : w_sout_next;
`else
            r_sout <= w_sout_next;
`endif
        end
    end

`ifndef UART_TX_BREAK_EN
    logic w_unused_bc;
    assign w_unused_bc = BC;
`endif

    assign SOUT       = r_sout;
    assign TXFINISHED = r_finished;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - scoreboard bench for uart_transmitter
module tb_uart_transmitter;

    localparam int OS = 16;

    typedef struct {
        logic lvl;
        logic last;
    } exp_t;

    logic       CLK;
    logic       RST_N;
    logic       TXCLK;
    logic       TXSTART;
    logic       CLEAR;
    logic [1:0] WLS;
    logic       STB;
    logic       PEN;
    logic       EPS;
    logic       SP;
    logic       BC;
    logic [7:0] DIN;
    logic       SOUT;
    logic       TXFINISHED;

    exp_t exp_q[$];
    logic pend_fin;
    int   n_checks;
    int   n_fail;

    uart_transmitter #(
        .OVERSAMPLE(OS)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .TXCLK     (TXCLK),
        .TXSTART   (TXSTART),
        .CLEAR     (CLEAR),
        .WLS       (WLS),
        .STB       (STB),
        .PEN       (PEN),
        .EPS       (EPS),
        .SP        (SP),
        .BC        (BC),
        .DIN       (DIN),
        .SOUT      (SOUT),
        .TXFINISHED(TXFINISHED)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Baud tick on every other clock; stimulus is always launched in a tick-free cycle.
    initial begin
        TXCLK = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            TXCLK = ~TXCLK;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_bits(input logic lvl, input int n, input logic last_flag);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.lvl  = lvl;
            e.last = last_flag && (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_frame(input logic [7:0] din, input logic [1:0] wls, input logic stb,
                              input logic pen, input logic eps, input logic sp);
        logic par;
        int   nbits;
        nbits = int'(wls) + 5;
        par   = 1'b0;
        push_bits(1'b0, OS, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            push_bits(din[i], OS, 1'b0);
            par = par ^ din[i];
        end
        if (pen) push_bits(sp ? ~eps : (par ^ ~eps), OS, 1'b0);
        if (stb) begin
            push_bits(1'b1, OS, 1'b0);
            push_bits(1'b1, (wls == 2'b00) ? OS / 2 : OS, 1'b1);
        end else begin
            push_bits(1'b1, OS, 1'b1);
        end
    endtask

    task automatic align;
        @(posedge CLK);
        #2;
        while (TXCLK) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic drive_start(input logic [7:0] din, input logic [1:0] wls, input logic stb,
                               input logic pen, input logic eps, input logic sp, input logic expect_frame);
        DIN = din; WLS = wls; STB = stb; PEN = pen; EPS = eps; SP = sp;
        TXSTART = 1'b1;
        if (expect_frame) push_frame(din, wls, stb, pen, eps, sp);
        @(posedge CLK);
        #2;
        TXSTART = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || pend_fin) && i < max_cycles) begin
            @(posedge CLK);
            #2;
            i++;
        end
        if (i >= max_cycles) check("timeout", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge CLK);
        #2;
    endtask

    task automatic wait_txfinished(input int max_cycles);
        int i;
        i = 0;
        @(posedge CLK);
        #2;
        while (TXFINISHED !== 1'b1 && i < max_cycles) begin
            @(posedge CLK);
            #2;
            i++;
        end
        if (i >= max_cycles) check("fin_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: one sample per baud tick, plus TXFINISHED exactly one cycle after the last tick.
    initial begin
        exp_t e;
        logic exp_fin;
        logic exp_lvl;
        pend_fin = 1'b0;
        forever begin
            @(negedge CLK);
            exp_fin  = pend_fin;
            pend_fin = 1'b0;
            if (exp_fin || TXFINISHED === 1'b1) check("txfinished", 32'(TXFINISHED), 32'(exp_fin));
            if (TXCLK && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                exp_lvl = e.lvl;
`ifdef UART_TX_BREAK_EN
                if (BC) exp_lvl = 1'b0;
`endif
                check("sout", 32'(SOUT), 32'(exp_lvl));
                if (e.last) pend_fin = 1'b1;
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RST_N = 1'b0; TXSTART = 1'b0; CLEAR = 1'b0; BC = 1'b0;
        WLS = 2'b11; STB = 1'b0; PEN = 1'b0; EPS = 1'b0; SP = 1'b0; DIN = 8'h00;
        repeat (3) @(posedge CLK);
        #2;
        check("rst_sout", 32'(SOUT), 32'd1);
        check("rst_fin", 32'(TXFINISHED), 32'd0);
        RST_N = 1'b1;
        repeat (4) @(posedge CLK);
        #2;
        check("idle_sout", 32'(SOUT), 32'd1);

        // 8N1 0x55, then 7E1 0x41 with even and odd parity
        align; drive_start(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); wait_done(2000);
        align; drive_start(8'h41, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1); wait_done(2000);
        align; drive_start(8'h41, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); wait_done(2000);

        // 5 data bits with 1.5 stop bits; stick parity
        align; drive_start(8'h1F, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); wait_done(2000);
        align; drive_start(8'h1F, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1); wait_done(2000);
        align; drive_start(8'hC6, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); wait_done(2000);

        // Mid-frame TXSTART with new config is ignored; back-to-back start on TXFINISHED
        align; drive_start(8'hA3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (100) @(posedge CLK);
        align; drive_start(8'h00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_txfinished(2000);
        check("b2b_fin", 32'(TXFINISHED), 32'd1);
        drive_start(8'h3C, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_done(2000);
        repeat (40) @(posedge CLK);
        #2;
        check("idle_after_b2b", 32'(SOUT), 32'd1);

        // CLEAR during DATA, with a simultaneous TXSTART that must lose
        align; drive_start(8'hF0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (128) @(posedge CLK);
        align;
        CLEAR = 1'b1; TXSTART = 1'b1;
        exp_q.delete();
        @(posedge CLK);
        #2;
        CLEAR = 1'b0; TXSTART = 1'b0;
        check("clear_sout", 32'(SOUT), 32'd1);
        repeat (400) @(posedge CLK);
        #2;
        check("clear_idle", 32'(SOUT), 32'd1);

        // Asynchronous reset during DATA
        align; drive_start(8'h0F, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (128) @(posedge CLK);
        align;
        RST_N = 1'b0;
        exp_q.delete();
        #1;
        check("rst_mid_sout", 32'(SOUT), 32'd1);
        check("rst_mid_fin", 32'(TXFINISHED), 32'd0);
        repeat (3) @(posedge CLK);
        #2;
        RST_N = 1'b1;
        repeat (400) @(posedge CLK);
        #2;
        check("rst_idle", 32'(SOUT), 32'd1);

        // Break asserted mid-frame
        align; drive_start(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (64) @(posedge CLK);
        align; BC = 1'b1;
        repeat (64) @(posedge CLK);
        align; BC = 1'b0;
        wait_done(2000);
        check("final_sout", 32'(SOUT), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
